// File: rtl/rs_syndrome_calc_pkg.sv
// Shared constants, types and GF(2^4) arithmetic for the RS(15,9) syndrome calculator.
package rs_syndrome_calc_pkg;

  localparam int unsigned DATA_WIDTH = 4;
  localparam int unsigned N_SYM      = 15;
  localparam int unsigned N_SYN      = 6;
  localparam int unsigned CNT_W      = 4;
  localparam logic [4:0]  PRIM_POLY  = 5'h13;

  typedef logic [DATA_WIDTH-1:0] gf_t;

  // Syndrome bundle: element 0 is S1, so S1 lands in bits [3:0] when flattened.
  typedef gf_t [N_SYN-1:0] syn_t;

  // alpha^1..alpha^6 with alpha = 2 under x^4+x+1.
  localparam syn_t ALPHA_POW = {4'hC, 4'h6, 4'h3, 4'h8, 4'h4, 4'h2};

  // Multiply by alpha (x) with reduction modulo the primitive polynomial.
  function automatic gf_t gf_xtime(input gf_t a);
    gf_t r;
    r = {a[DATA_WIDTH-2:0], 1'b0};
    if (a[DATA_WIDTH-1]) r = r ^ PRIM_POLY[DATA_WIDTH-1:0];
    return r;
  endfunction

  // Shift-and-add GF multiply; with one constant operand it folds to XORs.
  function automatic gf_t gf_mul(input gf_t a, input gf_t b);
    gf_t p;
    gf_t x;
    p = '0;
    x = a;
    for (int i = 0; i < int'(DATA_WIDTH); i++) begin
      if (b[i]) p = p ^ x;
      x = gf_xtime(x);
    end
    return p;
  endfunction

endpackage

// File: rtl/gf2_add.sv
// GF(2^m) addition: bitwise XOR of two symbols.
module gf2_add
  import rs_syndrome_calc_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] sum_c
);

  always_comb begin
    sum_c = a ^ b;
  end

endmodule

// File: rtl/gf2_mul_const.sv
// Combinational multiply of a GF(2^4) element by a fixed field constant.
module gf2_mul_const
  import rs_syndrome_calc_pkg::*;
#(
  parameter gf_t CONST = 4'h2
) (
  input  logic [DATA_WIDTH-1:0] a,
  output logic [DATA_WIDTH-1:0] prod_c
);

  always_comb begin
    prod_c = gf_mul(a, CONST);
  end

endmodule

// File: rtl/rs_syndrome_calc.sv
// RS(15,9) syndrome calculator: Horner evaluation of r(alpha^j), j=1..6, one symbol per clock.
module rs_syndrome_calc
  import rs_syndrome_calc_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic [DATA_WIDTH-1:0]       in_data,
  output logic                        out_valid,
  output logic [N_SYN*DATA_WIDTH-1:0] out_syndrome,
  output logic                        out_err,
  output logic                        busy
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  syn_t             acc_q, acc_d;
  syn_t             out_syn_q, out_syn_d;
  logic             out_valid_q, out_valid_d;
  logic             out_err_q, out_err_d;
  logic             busy_q, busy_d;

  syn_t             mul_c;
  syn_t             horner_c;
  logic             first_c;
  logic             last_c;

  // Per-syndrome datapath: acc*alpha^j + r
  for (genvar j = 0; j < int'(N_SYN); j++) begin : g_syn
    gf2_mul_const #(
      .CONST (ALPHA_POW[j])
    ) u_mul (
      .a      (acc_q[j]),
      .prod_c (mul_c[j])
    );

    gf2_add u_add (
      .a     (mul_c[j]),
      .b     (in_data),
      .sum_c (horner_c[j])
    );
  end

  always_comb begin
    first_c = (cnt_q == '0);
    last_c  = in_valid && (cnt_q == CNT_W'(N_SYM - 1));
  end

  // Next-state: counter, accumulators and result capture on the final symbol
  always_comb begin
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    out_syn_d   = out_syn_q;
    out_err_d   = out_err_q;
    out_valid_d = 1'b0;

    if (in_valid) begin
      cnt_d = last_c ? '0 : cnt_q + CNT_W'(1);
      for (int j = 0; j < int'(N_SYN); j++) begin
        acc_d[j] = first_c ? in_data : horner_c[j];
      end
      if (last_c) begin
        out_valid_d = 1'b1;
        out_syn_d   = acc_d;
        out_err_d   = |acc_d;
      end
    end

    busy_d = (cnt_d != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      acc_q       <= '0;
      out_syn_q   <= '0;
      out_err_q   <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      out_syn_q   <= out_syn_d;
      out_err_q   <= out_err_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_syndrome = out_syn_q;
  assign out_err      = out_err_q;
  assign busy         = busy_q;

endmodule
